// File: rtl/countdown_pkg.sv
// Shared types and default widths for the countdown sequencer.
package countdown_pkg;

  localparam int DEFAULT_BIT_WIDTH      = 5;
  localparam int DEFAULT_PRESCALE_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_prescaler.sv
// Down-counting prescaler: load has priority over enable, zero flag marks a tick slot.
module countdown_prescaler
  import countdown_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      load,
  input  logic                      en,
  input  logic [PRESCALE_WIDTH-1:0] reload_value,
  output logic                      zero
);

  localparam logic [PRESCALE_WIDTH-1:0] PZERO_C = {PRESCALE_WIDTH{1'b0}};
  localparam logic [PRESCALE_WIDTH-1:0] PONE_C  = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] count_r;

  assign zero = (count_r == PZERO_C);

  // Prescaler count register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_r <= PZERO_C;
    end else if (clr) begin
      count_r <= PZERO_C;
    end else if (load) begin
      count_r <= reload_value;
    end else if (en && !zero) begin
      count_r <= count_r - PONE_C;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Prescaled countdown sequencer (IDLE/RUN/DONE). Optional auto-reload in DONE is
// enabled by defining COUNTDOWN_AUTO_RELOAD_EN.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int BIT_WIDTH      = DEFAULT_BIT_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [BIT_WIDTH-1:0]      load_count,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      dec_en,
  input  logic                      abort,
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  input  logic                      auto_reload,
`endif
  output logic                      busy,
  output logic                      tick,
  output logic [BIT_WIDTH-1:0]      out,
  output logic                      done
);

  localparam logic [BIT_WIDTH-1:0]      ZERO_C  = {BIT_WIDTH{1'b0}};
  localparam logic [BIT_WIDTH-1:0]      ONE_C   = BIT_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PZERO_C = {PRESCALE_WIDTH{1'b0}};

  state_t                    state_r, state_nxt_s;
  logic [BIT_WIDTH-1:0]      out_r, out_nxt_s;
  logic [PRESCALE_WIDTH-1:0] reload_r, reload_nxt_s, presc_val_s;
  logic                      presc_load_s, presc_clr_s, presc_en_s, presc_zero_s;
  logic                      tick_s, done_s;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [BIT_WIDTH-1:0]      latched_r, latched_nxt_s;
`endif

  assign presc_en_s = (state_r == RUN) && dec_en;

  countdown_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk         (clk),
    .rstn        (rstn),
    .clr         (presc_clr_s),
    .load        (presc_load_s),
    .en          (presc_en_s),
    .reload_value(presc_val_s),
    .zero        (presc_zero_s)
  );

  // State, remaining count and prescale reload registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r  <= IDLE;
      out_r    <= ZERO_C;
      reload_r <= PZERO_C;
    end else begin
      state_r  <= state_nxt_s;
      out_r    <= out_nxt_s;
      reload_r <= reload_nxt_s;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Latched start count, replayed on each auto-reload
  always_ff @(posedge clk) begin
    if (!rstn) begin
      latched_r <= ZERO_C;
    end else begin
      latched_r <= latched_nxt_s;
    end
  end
`endif

  // Next-state, count update and strobes; abort outranks any tick or done
  always_comb begin
    state_nxt_s  = state_r;
    out_nxt_s    = out_r;
    reload_nxt_s = reload_r;
    presc_val_s  = reload_r;
    presc_load_s = 1'b0;
    presc_clr_s  = 1'b0;
    tick_s       = 1'b0;
    done_s       = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    latched_nxt_s = latched_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          out_nxt_s    = load_count;
          reload_nxt_s = prescale;
          presc_val_s  = prescale;
          presc_load_s = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          latched_nxt_s = load_count;
`endif
          state_nxt_s  = (load_count == ZERO_C) ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = IDLE;
          out_nxt_s   = ZERO_C;
          presc_clr_s = 1'b1;
        end else if (dec_en && presc_zero_s) begin
          tick_s       = 1'b1;
          presc_load_s = 1'b1;
          // Saturate at zero so the count can never wrap
          if (out_r <= ONE_C) begin
            out_nxt_s   = ZERO_C;
            state_nxt_s = DONE;
          end else begin
            out_nxt_s   = out_r - ONE_C;
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (abort) begin
          state_nxt_s = IDLE;
          out_nxt_s   = ZERO_C;
          presc_clr_s = 1'b1;
        end else begin
          done_s = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          if (auto_reload) begin
            out_nxt_s    = latched_r;
            presc_load_s = 1'b1;
            state_nxt_s  = (latched_r == ZERO_C) ? DONE : RUN;
          end else begin
            state_nxt_s = IDLE;
          end
`else
          state_nxt_s = IDLE;
`endif
        end
      end
      default: begin
        state_nxt_s = IDLE;
        out_nxt_s   = ZERO_C;
        presc_clr_s = 1'b1;
      end
    endcase
  end

  assign busy = (state_r != IDLE);
  assign tick = tick_s;
  assign done = done_s;
  assign out  = out_r;

endmodule
